// File: rtl/noc_flit_sink.sv
// Receive-side NoC endpoint: checks header destination, strips it, and forwards payload through a small FIFO.
// Optional NOC_SINK_LEN_CHECK_EN enables header LEN vs. body-count checking on err_len.
module noc_flit_sink #(
    parameter int Noc_Data_Width = 32,
    parameter int X_ID           = 0,
    parameter int Y_ID           = 0,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      noc_clk,
    input  logic                      noc_rst,
    input  logic                      receive_valid,
    output logic                      receive_ready,
    input  logic [Noc_Data_Width-1:0] receive_flit,
    input  logic                      receive_is_header,
    input  logic                      receive_is_tail,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [Noc_Data_Width-1:0] out_data,
    output logic                      out_last,
    output logic [3:0]                out_src_x,
    output logic [3:0]                out_src_y,
    output logic [7:0]                pkt_count,
    output logic                      err_dest,
    output logic                      err_proto,
    output logic                      err_len
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int EW = Noc_Data_Width + 9;

    typedef enum logic [1:0] {IDLE, PAYLOAD, DROP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        src_x_q, src_y_q;
    logic [7:0]        body_cnt_q, body_cnt_nxt;
    logic [EW-1:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       count_q;
    logic              fifo_full, rx_fire, out_fire, dest_match;
    logic              push, latch_hdr, pkt_inc, set_dest, set_proto;

    assign fifo_full    = (count_q == (PW+1)'(FIFO_DEPTH));
    assign out_valid    = (count_q != '0);
    assign rx_fire      = receive_valid & receive_ready;
    assign out_fire     = out_valid & out_ready;
    assign dest_match   = (receive_flit[7:4] == 4'(X_ID)) && (receive_flit[3:0] == 4'(Y_ID));
    assign body_cnt_nxt = (body_cnt_q == 8'hFF) ? 8'hFF : body_cnt_q + 8'd1;
    assign {out_data, out_last, out_src_x, out_src_y} = mem[rd_ptr];

    always_ff @(posedge noc_clk) begin
        if (noc_rst) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Ready is held low while reset is asserted so no flit is accepted in that cycle.
    always_comb begin
        state_d       = state_q;
        receive_ready = 1'b0;
        push          = 1'b0;
        latch_hdr     = 1'b0;
        pkt_inc       = 1'b0;
        set_dest      = 1'b0;
        set_proto     = 1'b0;
        if (!noc_rst) begin
            case (state_q)
                IDLE: begin
                    receive_ready = 1'b1;
                    if (rx_fire) begin
                        if (!receive_is_header) begin
                            set_proto = 1'b1;
                        end else if (dest_match) begin
                            if (receive_is_tail) begin
                                pkt_inc = 1'b1;
                            end else begin
                                latch_hdr = 1'b1;
                                state_d   = PAYLOAD;
                            end
                        end else begin
                            set_dest = 1'b1;
                            if (!receive_is_tail) state_d = DROP;
                        end
                    end
                end
                PAYLOAD: begin
                    receive_ready = !fifo_full;
                    if (rx_fire) begin
                        if (receive_is_header) begin
                            set_proto = 1'b1;
                        end else begin
                            push = 1'b1;
                            if (receive_is_tail) begin
                                pkt_inc = 1'b1;
                                state_d = IDLE;
                            end
                        end
                    end
                end
                DROP: begin
                    receive_ready = 1'b1;
                    if (rx_fire && receive_is_tail) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            src_x_q    <= '0;
            src_y_q    <= '0;
            body_cnt_q <= '0;
            pkt_count  <= '0;
            err_dest   <= 1'b0;
            err_proto  <= 1'b0;
        end else begin
            if (latch_hdr) begin
                src_x_q    <= receive_flit[15:12];
                src_y_q    <= receive_flit[11:8];
                body_cnt_q <= '0;
            end else if (push) begin
                body_cnt_q <= body_cnt_nxt;
            end
            if (pkt_inc)   pkt_count <= pkt_count + 8'd1;
            if (set_dest)  err_dest  <= 1'b1;
            if (set_proto) err_proto <= 1'b1;
        end
    end

`ifdef NOC_SINK_LEN_CHECK_EN
    logic [7:0] len_q;
    logic       err_len_q;

    // body_cnt_nxt counts the flit being accepted, so a well-formed tail lands exactly on LEN.
    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            len_q     <= '0;
            err_len_q <= 1'b0;
        end else begin
            if (latch_hdr) len_q <= receive_flit[23:16];
            if (push && ((receive_is_tail && body_cnt_nxt != len_q) ||
                         (!receive_is_tail && body_cnt_nxt == len_q)))
                err_len_q <= 1'b1;
        end
    end
    assign err_len = err_len_q;
`else
    assign err_len = 1'b0;
`endif

    // Entries are cleared on reset so out_* read as zero until the first word arrives.
    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {receive_flit, receive_is_tail, src_x_q, src_y_q};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (out_fire) rd_ptr <= rd_ptr + 1'b1;
            case ({push, out_fire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_flit_sink.sv
// Randomized scoreboard bench for noc_flit_sink: a packet-level model predicts payload words and status.
module tb_noc_flit_sink;
    localparam int W     = 32;
    localparam int DEPTH = 4;
`ifdef NOC_SINK_LEN_CHECK_EN
    localparam bit LEN_EN = 1'b1;
`else
    localparam bit LEN_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          noc_rst = 1'b1;
    logic          receive_valid = 1'b0, receive_ready;
    logic [W-1:0]  receive_flit = '0;
    logic          receive_is_header = 1'b0, receive_is_tail = 1'b0;
    logic          out_valid, out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic          out_last;
    logic [3:0]    out_src_x, out_src_y;
    logic [7:0]    pkt_count;
    logic          err_dest, err_proto, err_len;

    noc_flit_sink #(.Noc_Data_Width(W), .X_ID(1), .Y_ID(1), .FIFO_DEPTH(DEPTH)) dut (
        .noc_clk(clk), .noc_rst(noc_rst),
        .receive_valid(receive_valid), .receive_ready(receive_ready), .receive_flit(receive_flit),
        .receive_is_header(receive_is_header), .receive_is_tail(receive_is_tail),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .out_src_x(out_src_x), .out_src_y(out_src_y), .pkt_count(pkt_count),
        .err_dest(err_dest), .err_proto(err_proto), .err_len(err_len));

    always #5 clk = ~clk;

    typedef struct {logic [W-1:0] data; logic last; logic [3:0] sx, sy;} word_t;
    word_t exp_q[$];

    int checks = 0, errors = 0;
    bit started = 0;

    // Packet-level reference: 0 = waiting for header, 1 = inside a packet, 2 = dropping
    int         m_mode;
    logic [3:0] m_sx, m_sy;
    int         m_len, m_body;
    logic [7:0] m_pkt;
    logic       m_edest, m_eproto, m_elen;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] hdr(input int dx, dy, sx, sy, len);
        return {8'h00, 8'(len), 4'(sx), 4'(sy), 4'(dx), 4'(dy)};
    endfunction

    task automatic model_clear();
        exp_q.delete();
        m_mode = 0; m_sx = 0; m_sy = 0; m_len = 0; m_body = 0;
        m_pkt = 0; m_edest = 0; m_eproto = 0; m_elen = 0;
    endtask

    task automatic model_accept(input logic [W-1:0] f, input logic h, input logic t);
        word_t w;
        if (m_mode == 0) begin
            if (!h) m_eproto = 1;
            else if (f[7:4] == 4'd1 && f[3:0] == 4'd1) begin
                if (t) m_pkt++;
                else begin
                    m_sx = f[15:12]; m_sy = f[11:8]; m_len = int'(f[23:16]); m_body = 0; m_mode = 1;
                end
            end else begin
                m_edest = 1;
                if (!t) m_mode = 2;
            end
        end else if (m_mode == 1) begin
            if (h) m_eproto = 1;
            else begin
                w.data = f; w.last = t; w.sx = m_sx; w.sy = m_sy;
                exp_q.push_back(w);
                m_body = (m_body >= 255) ? 255 : m_body + 1;
                if (LEN_EN && ((t && m_body != m_len) || (!t && m_body == m_len))) m_elen = 1;
                if (t) begin m_pkt++; m_mode = 0; end
            end
        end else if (t) begin
            m_mode = 0;
        end
    endtask

    // One cycle: drive after negedge, check status at +1, let the monitor run at +2, update model at +3.
    task automatic step(input logic v, input logic [W-1:0] f, input logic h, input logic t,
                        input int om, output logic acc);
        logic exp_rdy;
        @(negedge clk);
        receive_valid = v; receive_flit = f; receive_is_header = h; receive_is_tail = t;
        out_ready = (om == 2) ? ($urandom_range(3) != 0) : (om == 1);
        #1;
        exp_rdy = (m_mode != 1) || (exp_q.size() < DEPTH);
        chk("receive_ready", W'(receive_ready), W'(exp_rdy));
        chk("pkt_count", W'(pkt_count), W'(m_pkt));
        chk("err_dest", W'(err_dest), W'(m_edest));
        chk("err_proto", W'(err_proto), W'(m_eproto));
        chk("err_len", W'(err_len), W'(m_elen));
        acc = v && receive_ready;
        #2;
        if (acc) model_accept(f, h, t);
    endtask

    task automatic send(input logic [W-1:0] f, input logic h, input logic t, input int om);
        logic acc = 1'b0;
        for (int i = 0; i < 64 && !acc; i++) step(1'b1, f, h, t, om, acc);
        if (!acc) begin
            errors++;
            $display("FAIL send_timeout: flit %0h not accepted within 64 cycles", f);
        end
    endtask

    task automatic idle(input int n, input int om);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, om, acc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        noc_rst = 1; receive_valid = 0; out_ready = 0;
        #1;
        chk("ready_in_reset", W'(receive_ready), '0);
        model_clear();
        @(posedge clk);
        #1;
        noc_rst = 0;
        chk("rst_out_valid", W'(out_valid), '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_last", W'(out_last), '0);
        chk("rst_out_src", W'({out_src_x, out_src_y}), '0);
        chk("rst_pkt_count", W'(pkt_count), '0);
        chk("rst_errs", W'({err_dest, err_proto, err_len}), '0);
        started = 1;
    endtask

    // Monitor: every accepted output word must match the head of the expected queue.
    always @(negedge clk) begin
        word_t w;
        #2;
        if (started && !noc_rst) begin
            chk("out_valid", W'(out_valid), W'(exp_q.size() != 0));
            if (out_valid && out_ready && exp_q.size() != 0) begin
                w = exp_q.pop_front();
                chk("out_data", out_data, w.data);
                chk("out_last", W'(out_last), W'(w.last));
                chk("out_src_x", W'(out_src_x), W'(w.sx));
                chk("out_src_y", W'(out_src_y), W'(w.sy));
            end
        end
    end

    initial begin
        logic [W-1:0] f;
        int n, r;
        model_clear();
        do_reset();
        idle(2, 1);

        // basic packet, consumer always ready
        send(32'h00030011, 1, 0, 1);
        send(32'hA1, 0, 0, 1); send(32'hA2, 0, 0, 1); send(32'hA3, 0, 1, 1);
        idle(3, 1);

        // backpressure: fill the FIFO, then drain
        send(32'h00030011, 1, 0, 0);
        send(32'hA1, 0, 0, 0); send(32'hA2, 0, 0, 0); send(32'hA3, 0, 1, 0);
        send(32'h00030011, 1, 0, 0);
        send(32'hB1, 0, 0, 0);
        idle(2, 0);
        send(32'hB2, 0, 0, 1);
        send(32'hB3, 0, 1, 1);
        idle(6, 1);

        // wrong destination, then packets dropped silently
        send(32'h00020000, 1, 0, 1);
        send(32'hC1, 0, 0, 1); send(32'hC2, 0, 1, 1);
        idle(2, 1);

        // protocol errors: body in IDLE, header inside a packet
        send(32'hD0, 0, 0, 1);
        send(hdr(1, 1, 5, 6, 3), 1, 0, 1);
        send(32'hD1, 0, 0, 1);
        send(hdr(1, 1, 7, 7, 2), 1, 0, 1);
        send(32'hD2, 0, 0, 1); send(32'hD3, 0, 1, 1);
        idle(2, 1);

        // header-only packet, then LEN=3 with tail after two flits
        send(hdr(1, 1, 2, 3, 0), 1, 1, 1);
        send(hdr(1, 1, 9, 4, 3), 1, 0, 1);
        send(32'hE1, 0, 0, 1); send(32'hE2, 0, 1, 1);
        idle(3, 1);

        // reset in the middle of a packet with words still queued
        send(hdr(1, 1, 3, 3, 4), 1, 0, 0);
        send(32'hF1, 0, 0, 0); send(32'hF2, 0, 0, 0);
        do_reset();
        idle(2, 1);

        // randomized packets with gaps, random backpressure and occasional junk
        for (int p = 0; p < 150; p++) begin
            r = $urandom_range(99);
            n = $urandom_range(5);
            if (r < 5) send($urandom, 0, $urandom_range(1), 2);
            f = hdr((r < 88) ? 1 : $urandom_range(15), (r < 88) ? 1 : $urandom_range(15),
                    $urandom_range(15), $urandom_range(15), n + 1);
            send(f, 1, (n == 0) && ($urandom_range(3) == 0), 2);
            for (int b = 0; b <= n; b++) begin
                if ($urandom_range(3) == 0) idle($urandom_range(2) + 1, 2);
                if ($urandom_range(49) == 0) send($urandom, 1, 0, 2);
                send($urandom, 0, b == n, 2);
            end
        end
        idle(20, 1);
        chk("queue_drained", W'(exp_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
